// File: rtl/core_status.sv
// rtl/core_status.sv - 6502 processor status register with interrupt poll front end
// Holds C,Z,I,D,V,N, builds the push image and latches NMI/IRQ at instruction boundaries.

module core_status (
    input  logic       I_clock,
    input  logic       I_reset,
    input  logic       I_ready,
    input  logic       I_alu_we,
    input  logic       I_alu_carry,
    input  logic       I_alu_overflow,
    input  logic       I_alu_sign,
    input  logic       I_alu_zero,
    input  logic       I_pull,
    input  logic [7:0] I_data,
    input  logic       I_flag_op_en,
    input  logic [2:0] I_flag_op,
    input  logic       I_int_enter,
    input  logic       I_brk,
    input  logic       I_irq_n,
    input  logic       I_nmi_n,
    input  logic       I_poll,
    input  logic       I_nmi_ack,
    output logic       O_carry,
    output logic       O_overflow,
    output logic       O_sign,
    output logic       O_zero,
    output logic       O_decimal,
    output logic       O_irq_disable,
    output logic [7:0] O_p,
    output logic       O_int_pending,
    output logic       O_int_nmi
);

    localparam logic [2:0] OP_CLC = 3'd0;
    localparam logic [2:0] OP_SEC = 3'd1;
    localparam logic [2:0] OP_CLI = 3'd2;
    localparam logic [2:0] OP_SEI = 3'd3;
    localparam logic [2:0] OP_CLV = 3'd4;
    localparam logic [2:0] OP_CLD = 3'd5;
    localparam logic [2:0] OP_SED = 3'd6;

    logic c_q, z_q, i_q, d_q, v_q, n_q;
    logic c_d, z_d, i_d, d_d, v_d, n_d;
    logic nmi_prev_q, nmi_pending_q, nmi_lat_q, irq_lat_q;
    logic nmi_pending_d, nmi_lat_d, irq_lat_d;
    logic op_clc, op_sec, op_cli, op_sei, op_clv, op_cld, op_sed;
    logic nmi_edge, poll_now;

    assign op_clc = I_flag_op_en && (I_flag_op == OP_CLC);
    assign op_sec = I_flag_op_en && (I_flag_op == OP_SEC);
    assign op_cli = I_flag_op_en && (I_flag_op == OP_CLI);
    assign op_sei = I_flag_op_en && (I_flag_op == OP_SEI);
    assign op_clv = I_flag_op_en && (I_flag_op == OP_CLV);
    assign op_cld = I_flag_op_en && (I_flag_op == OP_CLD);
    assign op_sed = I_flag_op_en && (I_flag_op == OP_SED);

    assign nmi_edge = nmi_prev_q && !I_nmi_n;
    assign poll_now = I_ready && I_poll;

    // Per-bit priority chains; each bit holds unless one of its own sources fires.
    always_comb begin
        c_d = c_q;
        z_d = z_q;
        i_d = i_q;
        d_d = d_q;
        v_d = v_q;
        n_d = n_q;
        if (I_ready) begin
            if (I_int_enter)  i_d = 1'b1;
            else if (I_pull)  i_d = I_data[2];
            else if (op_cli)  i_d = 1'b0;
            else if (op_sei)  i_d = 1'b1;

            if (I_pull)        c_d = I_data[0];
            else if (I_alu_we) c_d = I_alu_carry;
            else if (op_clc)   c_d = 1'b0;
            else if (op_sec)   c_d = 1'b1;

            if (I_pull)        z_d = I_data[1];
            else if (I_alu_we) z_d = I_alu_zero;

            if (I_pull)        v_d = I_data[6];
            else if (I_alu_we) v_d = I_alu_overflow;
            else if (op_clv)   v_d = 1'b0;

            if (I_pull)        n_d = I_data[7];
            else if (I_alu_we) n_d = I_alu_sign;

            if (I_pull)        d_d = I_data[3];
            else if (op_cld)   d_d = 1'b0;
            else if (op_sed)   d_d = 1'b1;
        end
    end

    // IRQ uses the pre-update I so CLI/SEI/PLP only take effect at the following poll.
    always_comb begin
        nmi_pending_d = nmi_pending_q;
        nmi_lat_d     = nmi_lat_q;
        irq_lat_d     = irq_lat_q;
        if (nmi_edge)
            nmi_pending_d = 1'b1;
        else if (I_ready && I_nmi_ack)
            nmi_pending_d = 1'b0;
        if (poll_now) begin
            nmi_lat_d = nmi_pending_q;
            irq_lat_d = !I_irq_n && !i_q;
        end else if (I_ready && I_int_enter) begin
            nmi_lat_d = 1'b0;
            irq_lat_d = 1'b0;
        end
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            c_q           <= 1'b0;
            z_q           <= 1'b0;
            i_q           <= 1'b1;
            d_q           <= 1'b0;
            v_q           <= 1'b0;
            n_q           <= 1'b0;
            nmi_prev_q    <= 1'b1;
            nmi_pending_q <= 1'b0;
            nmi_lat_q     <= 1'b0;
            irq_lat_q     <= 1'b0;
        end else begin
            c_q           <= c_d;
            z_q           <= z_d;
            i_q           <= i_d;
            d_q           <= d_d;
            v_q           <= v_d;
            n_q           <= n_d;
            nmi_prev_q    <= I_nmi_n;
            nmi_pending_q <= nmi_pending_d;
            nmi_lat_q     <= nmi_lat_d;
            irq_lat_q     <= irq_lat_d;
        end
    end

    assign O_carry       = c_q;
    assign O_overflow    = v_q;
    assign O_sign        = n_q;
    assign O_zero        = z_q;
    assign O_decimal     = d_q;
    assign O_irq_disable = i_q;
    assign O_p           = {n_q, v_q, 1'b1, I_brk, d_q, i_q, z_q, c_q};
    assign O_int_pending = nmi_lat_q || irq_lat_q;
    assign O_int_nmi     = nmi_lat_q;

endmodule

// File: tb/tb_core_status.sv
// tb/tb_core_status.sv - table-driven self-checking bench for core_status

module tb_core_status;

    logic       I_clock = 1'b0;
    logic       I_reset, I_ready, I_alu_we;
    logic       I_alu_carry, I_alu_overflow, I_alu_sign, I_alu_zero;
    logic       I_pull;
    logic [7:0] I_data;
    logic       I_flag_op_en;
    logic [2:0] I_flag_op;
    logic       I_int_enter, I_brk, I_irq_n, I_nmi_n, I_poll, I_nmi_ack;
    logic       O_carry, O_overflow, O_sign, O_zero, O_decimal, O_irq_disable;
    logic [7:0] O_p;
    logic       O_int_pending, O_int_nmi;

    int checks = 0;
    int errors = 0;

    core_status dut (
        .I_clock(I_clock), .I_reset(I_reset), .I_ready(I_ready), .I_alu_we(I_alu_we),
        .I_alu_carry(I_alu_carry), .I_alu_overflow(I_alu_overflow),
        .I_alu_sign(I_alu_sign), .I_alu_zero(I_alu_zero),
        .I_pull(I_pull), .I_data(I_data), .I_flag_op_en(I_flag_op_en), .I_flag_op(I_flag_op),
        .I_int_enter(I_int_enter), .I_brk(I_brk), .I_irq_n(I_irq_n), .I_nmi_n(I_nmi_n),
        .I_poll(I_poll), .I_nmi_ack(I_nmi_ack),
        .O_carry(O_carry), .O_overflow(O_overflow), .O_sign(O_sign), .O_zero(O_zero),
        .O_decimal(O_decimal), .O_irq_disable(O_irq_disable), .O_p(O_p),
        .O_int_pending(O_int_pending), .O_int_nmi(O_int_nmi)
    );

    always #5 I_clock = ~I_clock;

    typedef struct {
        logic       rst, rdy, alu_we;
        logic [3:0] cvsz;
        logic       pull;
        logic [7:0] data;
        logic       fen;
        logic [2:0] fop;
        logic       ent, brk, irq_n, nmi_n, poll, ack;
        logic [7:0] ep;
        logic       epend, enmi;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, rdy, alu_we, input logic [3:0] cvsz,
                                input logic pull, input logic [7:0] data,
                                input logic fen, input logic [2:0] fop,
                                input logic ent, brk, irq_n, nmi_n, poll, ack,
                                input logic [7:0] ep, input logic epend, enmi);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.alu_we = alu_we; v.cvsz = cvsz;
        v.pull = pull; v.data = data; v.fen = fen; v.fop = fop;
        v.ent = ent; v.brk = brk; v.irq_n = irq_n; v.nmi_n = nmi_n;
        v.poll = poll; v.ack = ack; v.ep = ep; v.epend = epend; v.enmi = enmi;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        I_reset = v.rst; I_ready = v.rdy; I_alu_we = v.alu_we;
        {I_alu_carry, I_alu_overflow, I_alu_sign, I_alu_zero} = v.cvsz;
        I_pull = v.pull; I_data = v.data; I_flag_op_en = v.fen; I_flag_op = v.fop;
        I_int_enter = v.ent; I_brk = v.brk; I_irq_n = v.irq_n; I_nmi_n = v.nmi_n;
        I_poll = v.poll; I_nmi_ack = v.ack;
    endtask

    task automatic check(input string name, input logic [7:0] ep, input logic epend, enmi);
        logic [5:0] eflags;
        logic [5:0] aflags;
        eflags = {ep[7], ep[6], ep[3], ep[2], ep[1], ep[0]};
        aflags = {O_sign, O_overflow, O_decimal, O_irq_disable, O_zero, O_carry};
        checks++;
        if (O_p !== ep) begin
            errors++;
            $display("FAIL %s p: got %02h expected %02h", name, O_p, ep);
        end
        checks++;
        if (aflags !== eflags) begin
            errors++;
            $display("FAIL %s flags NVDIZC: got %06b expected %06b", name, aflags, eflags);
        end
        checks++;
        if ({O_int_pending, O_int_nmi} !== {epend, enmi}) begin
            errors++;
            $display("FAIL %s pending/nmi: got %b%b expected %b%b", name,
                     O_int_pending, O_int_nmi, epend, enmi);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        @(negedge I_clock);
        apply(v);
        @(posedge I_clock);
        #1;
        check(name, v.ep, v.epend, v.enmi);
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,1,0,4'b0000,0,8'h00,0,3'd7,0,0,1,1,0,0, 8'h24,0,0);
        apply(idle);

        //            rst rdy we cvsz    pl data  fen op  ent brk irq nmi pol ack  p    pend nmi
        tbl.push_back(mk(1,1,0,4'b0000,0,8'h00,0,3'd7,0,0,1,1,0,0, 8'h24,0,0)); // reset
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,0,1,1,1,0,0, 8'h34,0,0)); // brk image
        tbl.push_back(mk(0,1,1,4'b1001,0,8'h00,1,3'd0,0,0,1,1,0,0, 8'h27,0,0)); // alu beats CLC
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,1,3'd0,0,0,1,1,0,0, 8'h26,0,0)); // CLC
        tbl.push_back(mk(0,1,0,4'b0000,1,8'hFF,1,3'd5,0,0,1,1,0,0, 8'hEF,0,0)); // PLP beats CLD
        tbl.push_back(mk(0,1,0,4'b0000,1,8'h04,0,3'd7,0,0,1,1,0,0, 8'h24,0,0)); // PLP 04
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,1,3'd1,0,0,1,1,0,0, 8'h25,0,0)); // SEC
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,1,3'd6,0,0,1,1,0,0, 8'h2D,0,0)); // SED
        tbl.push_back(mk(0,1,1,4'b0110,0,8'h00,0,3'd7,0,0,1,1,0,0, 8'hEC,0,0)); // alu V,N
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,1,3'd4,0,0,1,1,0,0, 8'hAC,0,0)); // CLV
        tbl.push_back(mk(0,1,0,4'b0000,1,8'h00,0,3'd7,1,0,1,1,0,0, 8'h24,0,0)); // int_enter beats PLP I
        // IRQ and the one-instruction I delay
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,1,3'd2,0,0,0,1,1,0, 8'h20,0,0)); // CLI+poll
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,0,0,0,1,1,0, 8'h20,1,0)); // poll -> irq
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,0,0,1,1,0,0, 8'h20,1,0)); // hold
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,1,0,1,1,0,0, 8'h24,0,0)); // enter
        tbl.push_back(mk(0,1,0,4'b0000,1,8'h00,0,3'd7,0,0,0,1,1,0, 8'h20,0,0)); // PLP I=0 + poll
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,0,0,0,1,1,0, 8'h20,1,0)); // next poll
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,1,3'd3,0,0,0,1,1,0, 8'h24,1,0)); // SEI+poll
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,0,0,0,1,1,0, 8'h24,0,0)); // masked
        // NMI
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,0,0,1,0,0,0, 8'h24,0,0)); // edge
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,0,0,1,0,1,0, 8'h24,1,1)); // poll
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,1,0,1,0,0,1, 8'h24,0,0)); // enter+ack
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,0,0,1,1,1,0, 8'h24,0,0)); // acked
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,0,0,1,0,0,1, 8'h24,0,0)); // ack+edge
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,0,0,1,0,1,0, 8'h24,1,1)); // still pending
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,1,0,1,0,1,0, 8'h24,1,1)); // poll beats enter
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,0,0,1,0,0,1, 8'h24,1,1)); // ack
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,0,0,1,1,1,0, 8'h24,0,0)); // cleared
        // RDY low freezes everything except the NMI edge
        tbl.push_back(mk(0,0,1,4'b1111,1,8'hFF,1,3'd6,1,0,0,0,1,1, 8'h24,0,0));
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,0,0,1,0,1,0, 8'h24,1,1)); // edge kept
        tbl.push_back(mk(1,1,1,4'b1111,1,8'hFF,1,3'd1,0,0,0,1,1,0, 8'h24,0,0)); // reset wins
        tbl.push_back(mk(0,1,0,4'b0000,0,8'h00,0,3'd7,0,0,1,1,1,0, 8'h24,0,0)); // NMI discarded

        foreach (tbl[k]) step(tbl[k], $sformatf("vec%0d", k));

        // Edge while RDY is held low for several cycles, then released.
        begin
            vec_t v;
            v = idle;
            v.rdy = 1'b0;
            v.nmi_n = 1'b0;
            v.poll = 1'b1;
            for (int n = 0; n < 4; n++) step(v, $sformatf("rdy_low%0d", n));
            v.rdy = 1'b1;
            v.poll = 1'b0;
            step(v, "rdy_release");
            v.poll = 1'b1;
            v.epend = 1'b1;
            v.enmi = 1'b1;
            step(v, "rdy_poll");
        end

        // Mid-instruction reset after a latched NMI returns to reset values.
        begin
            vec_t v;
            v = idle;
            v.rst = 1'b1;
            v.nmi_n = 1'b0;
            v.brk = 1'b1;
            v.ep = 8'h34;
            step(v, "reset_mid");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
